// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - mode codes and FSM states for the universal shift register
// Purpose: shared definitions for shift_reg_step and shift_reg_univ.
// Contents: 3-bit mode encodings, burst FSM state enum, shift-mode classifier.
package shift_reg_pkg;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_SAR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_LOAD = 3'b110;
  localparam logic [2:0] M_RSVD = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // True for the modes that actually move bits; only these spend RUN cycles in a burst.
  function automatic logic is_shift(input logic [2:0] m);
    return (m != M_HOLD) && (m != M_LOAD) && (m != M_RSVD);
  endfunction

endpackage

// File: rtl/shift_reg_step.sv
// rtl/shift_reg_step.sv - combinational one-step next value of the shift register
// Purpose: computes q_next from q for a single hold/shift/rotate/load step.
// Ports:
//   q       in  WIDTH  current register contents
//   mode    in  3      operation select (shift_reg_pkg mode codes)
//   s_in_l  in  1      serial bit entering bit 0 on SHL
//   s_in_r  in  1      serial bit entering bit WIDTH-1 on SHR
//   p_in    in  WIDTH  parallel load data
//   q_next  out WIDTH  contents after one step
import shift_reg_pkg::*;

module shift_reg_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             s_in_l,
  input  logic             s_in_r,
  input  logic [WIDTH-1:0] p_in,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (mode)
      M_SHL:   q_next = {q[WIDTH-2:0], s_in_l};
      M_SHR:   q_next = {s_in_r, q[WIDTH-1:1]};
      M_SAR:   q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      M_ROL:   q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      M_ROR:   q_next = {q[0], q[WIDTH-1:1]};
      M_LOAD:  q_next = p_in;
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/shift_reg_univ.sv
// rtl/shift_reg_univ.sv - universal shift register with autonomous burst mode
// Purpose: per-cycle hold/load/shift/rotate register plus a burst engine that
//          applies a latched shift mode shamt times, then pulses done.
// Ports:
//   clk      in  1      rising-edge clock
//   rst      in  1      asynchronous active-high reset
//   en       in  1      step enable for per-cycle modes
//   mode     in  3      operation select
//   s_in_l   in  1      serial input for SHL
//   s_in_r   in  1      serial input for SHR
//   p_in     in  WIDTH  parallel load data
//   start    in  1      burst request, sampled only in IDLE
//   shamt    in  CNT_W  burst shift count (values above WIDTH clamp to WIDTH)
//   Q        out WIDTH  register contents
//   s_out_l  out 1      Q[WIDTH-1]
//   s_out_r  out 1      Q[0]
//   busy     out 1      burst in progress (registered)
//   done     out 1      one-cycle burst-finished pulse (registered)
import shift_reg_pkg::*;

module shift_reg_univ #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             s_in_l,
  input  logic             s_in_r,
  input  logic [WIDTH-1:0] p_in,
  input  logic             start,
  input  logic [CNT_W-1:0] shamt,
  output logic [WIDTH-1:0] Q,
  output logic             s_out_l,
  output logic             s_out_r,
  output logic             busy,
  output logic             done
);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       burst_mode, burst_mode_n;
  logic [WIDTH-1:0] q_n, q_step;
  logic [2:0]       step_mode;
  logic [CNT_W-1:0] shamt_c;

  assign shamt_c = (shamt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : shamt;

  // The step unit is shared: the latched burst mode drives it while running,
  // the live mode input otherwise.
  assign step_mode = (state == RUN) ? burst_mode : mode;

  shift_reg_step #(.WIDTH(WIDTH)) u_step (
    .q      (Q),
    .mode   (step_mode),
    .s_in_l (s_in_l),
    .s_in_r (s_in_r),
    .p_in   (p_in),
    .q_next (q_step)
  );

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    burst_mode_n = burst_mode;
    q_n          = Q;
    case (state)
      IDLE: begin
        if (start) begin
          burst_mode_n = mode;
          cnt_n        = shamt_c;
          // Non-moving modes or a zero count skip straight to the done pulse.
          state_n      = (is_shift(mode) && (shamt_c != '0)) ? RUN : DONE;
        end else if (en) begin
          q_n = q_step;
        end
      end
      RUN: begin
        q_n   = q_step;
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_n = DONE;
      end
      DONE: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      burst_mode <= M_HOLD;
      Q          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      burst_mode <= burst_mode_n;
      Q          <= q_n;
      busy       <= (state_n == RUN);
      done       <= (state_n == DONE);
    end
  end

  assign s_out_l = Q[WIDTH-1];
  assign s_out_r = Q[0];

endmodule
